// File: rtl/l_stf_seq.sv
// L-STF preamble sequencer: walks the 16-entry L-STF ROM N_REP times and streams the
// samples out on a valid/ready interface, optionally halving the leading sample.
module l_stf_seq #(
    parameter int unsigned N_REP     = 10,
    parameter bit          WINDOW_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        abort,
    output logic [3:0]  rom_addr,
    input  logic [31:0] rom_dout,
    output logic [31:0] sample_iq,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        sample_last,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [7:0] END = 8'(N_REP * 16 - 1);

    logic [1:0]  state;
    logic [7:0]  cnt;
    logic        do_load;
    logic [31:0] win_iq;
    logic [31:0] load_iq;

    assign rom_addr = cnt[3:0];

    // The first sample is loaded in the start cycle itself so it is valid one cycle later.
    assign do_load = (state == IDLE && start && !done) ||
                     (state == RUN && (!sample_valid || sample_ready));

    assign win_iq  = {16'($signed(rom_dout[31:16]) >>> 1),
                      16'($signed(rom_dout[15:0]) >>> 1)};
    assign load_iq = (WINDOW_EN && cnt == 8'd0) ? win_iq : rom_dout;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            sample_iq    <= 32'd0;
            sample_valid <= 1'b0;
            sample_last  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                if (state != IDLE) begin
                    state        <= IDLE;
                    cnt          <= 8'd0;
                    sample_valid <= 1'b0;
                    sample_last  <= 1'b0;
                    busy         <= 1'b0;
                end
            end else begin
                if (do_load) begin
                    sample_iq    <= load_iq;
                    sample_valid <= 1'b1;
                    sample_last  <= (cnt == END);
                    cnt          <= (cnt == END) ? 8'd0 : cnt + 8'd1;
                end
                case (state)
                    IDLE: begin
                        if (start && !done) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (do_load && cnt == END) state <= DRAIN;
                    end
                    DRAIN: begin
                        if (sample_ready) begin
                            sample_valid <= 1'b0;
                            sample_last  <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            state        <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
